delay_arbiter: RTL

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/delay_arbiter.sv
// Four-way round-robin arbiter that lends one shared delay counter to the winner and pulses done when N cycles have elapsed.
// Optional sticky early-release checker on err, enabled by defining DELAY_ARBITER_PROTOCOL_CHECK_EN.
module delay_arbiter #(
   parameter int N     = 200000,
   parameter int CBITS = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [3:0] done,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

   localparam logic [CBITS-1:0] LAST = CBITS'(N - 1);

   state_t           state, state_nxt;
   logic [CBITS-1:0] cnt;
   logic             at_end;
   logic [1:0]       rr_ptr;
   logic [1:0]       winner;
   logic [1:0]       pick;
   logic             found;

   // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!found && req[rr_ptr + 2'(k)]) begin
            pick  = rr_ptr + 2'(k);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (found) state_nxt = LOAD;
         LOAD:  state_nxt = COUNT;
         COUNT: if (at_end) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         at_end <= 1'b0;
         rr_ptr <= 2'd0;
         winner <= 2'd0;
         gnt    <= 4'b0000;
         done   <= 4'b0000;
         busy   <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         unique case (state)
            IDLE: begin
               if (found) begin
                  winner <= pick;
                  gnt    <= 4'b0001 << pick;
               end
            end
            LOAD: begin
               cnt    <= '0;
               at_end <= 1'b0;
            end
            COUNT: begin
               // Terminal count is registered so the wide compare stays off the next-state path; cnt saturates at N-1.
               if (cnt != LAST) cnt <= cnt + 1'b1;
               at_end <= (cnt == LAST);
               if (at_end) done <= gnt;
            end
            DONE: begin
               gnt    <= 4'b0000;
               done   <= 4'b0000;
               rr_ptr <= winner + 2'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef DELAY_ARBITER_PROTOCOL_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if ((state == LOAD || state == COUNT) && !req[winner])
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
